// File: rtl/reg_file_mp_if.sv
// Bundled read, write and scoreboard signals of the multi-port register file.
// master drives the requests; slave is the register file itself.
interface reg_file_mp_if #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_RD = 3,
  parameter int unsigned NUM_WR = 2
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NUM_WR-1:0]       we;
  logic [NUM_WR*AW-1:0]    waddr;
  logic [NUM_WR*WIDTH-1:0] wdata;
  logic [NUM_RD*AW-1:0]    raddr;
  logic [NUM_RD*WIDTH-1:0] rdata;
  logic                    busy_set;
  logic [AW-1:0]           busy_set_addr;
  logic [NUM_RD-1:0]       rbusy;
  logic [DEPTH-1:0]        busy_vec;
  logic                    wr_conflict;

  modport master (
    output we, waddr, wdata, raddr, busy_set, busy_set_addr,
    input  rdata, rbusy, busy_vec, wr_conflict
  );

  modport slave (
    input  we, waddr, wdata, raddr, busy_set, busy_set_addr,
    output rdata, rbusy, busy_vec, wr_conflict
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with optional hardwired entry 0, optional write-to-read
// bypass and a busy-bit scoreboard for hazard detection.
module reg_file_mp #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_RD   = 3,
  parameter int unsigned NUM_WR   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input logic          clk,
  input logic          reset_n,
  reg_file_mp_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic [WIDTH-1:0]        mem_d [DEPTH];
  logic [DEPTH-1:0]        busy_q, busy_d;
  logic                    wr_conflict_q, wr_conflict_d;

  logic [NUM_WR-1:0]       wr_eff;
  logic [AW-1:0]           wr_addr [NUM_WR];
  logic [WIDTH-1:0]        wr_data [NUM_WR];
  logic [AW-1:0]           rd_addr [NUM_RD];
  logic [NUM_RD*WIDTH-1:0] rdata;
  logic [NUM_RD-1:0]       rbusy;

  // An address is live when it maps to a real entry that is not the hardwired zero.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  always_comb begin
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      wr_addr[p] = bus.waddr[p*AW +: AW];
      wr_data[p] = bus.wdata[p*WIDTH +: WIDTH];
      wr_eff[p]  = bus.we[p] && addr_live(wr_addr[p]);
    end
  end

  always_comb begin
    mem_d         = mem_q;
    busy_d        = busy_q;
    wr_conflict_d = 1'b0;
    // Ascending order so the highest-index port lands last and wins.
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      if (wr_eff[p]) begin
        mem_d[wr_addr[p]]  = wr_data[p];
        busy_d[wr_addr[p]] = 1'b0;
      end
    end
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      for (int unsigned q = p + 1; q < NUM_WR; q++) begin
        if (wr_eff[p] && wr_eff[q] && (wr_addr[p] == wr_addr[q])) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
    // A new producer issuing while the old one retires keeps the register busy.
    if (bus.busy_set && addr_live(bus.busy_set_addr)) begin
      busy_d[bus.busy_set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q        <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      busy_q        <= busy_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      rd_addr[r] = bus.raddr[r*AW +: AW];
      if (addr_live(rd_addr[r])) begin
        rdata[r*WIDTH +: WIDTH] = mem_q[rd_addr[r]];
        rbusy[r]                = busy_q[rd_addr[r]];
        if (BYPASS) begin
          for (int unsigned p = 0; p < NUM_WR; p++) begin
            if (wr_eff[p] && (wr_addr[p] == rd_addr[r])) begin
              rdata[r*WIDTH +: WIDTH] = wr_data[p];
              rbusy[r]                = 1'b0;
            end
          end
        end
      end
    end
  end

  assign bus.rdata       = rdata;
  assign bus.rbusy       = rbusy;
  assign bus.busy_vec    = busy_q;
  assign bus.wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: an integer-style file (x0 hardwired, bypass) and an FP-style file
// (no x0, no bypass) share one stimulus stream and are checked against a behavioural model.
module tb_reg_file_mp;
  localparam int unsigned DEPTH  = 24;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned NUM_RD = 3;
  localparam int unsigned NUM_WR = 3;
  localparam int unsigned AW     = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  reg_file_mp_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus_a ();
  reg_file_mp_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus_b ();

  assign bus_b.we            = bus_a.we;
  assign bus_b.waddr         = bus_a.waddr;
  assign bus_b.wdata         = bus_a.wdata;
  assign bus_b.raddr         = bus_a.raddr;
  assign bus_b.busy_set      = bus_a.busy_set;
  assign bus_b.busy_set_addr = bus_a.busy_set_addr;

  reg_file_mp #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
    .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a)
  );

  reg_file_mp #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
    .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b)
  );

  // Reference state; index 0 = integer-style config, 1 = FP-style config.
  logic [WIDTH-1:0] m_mem  [2][DEPTH];
  logic             m_busy [2][DEPTH];
  logic             m_conf [2];

  function automatic logic [AW-1:0] wa(int p);
    return bus_a.waddr[p*AW +: AW];
  endfunction

  function automatic logic [WIDTH-1:0] wd(int p);
    return bus_a.wdata[p*WIDTH +: WIDTH];
  endfunction

  function automatic logic [AW-1:0] ra(int r);
    return bus_a.raddr[r*AW +: AW];
  endfunction

  function automatic bit live(int c, logic [AW-1:0] a);
    return (int'(a) < int'(DEPTH)) && !(c == 0 && a == 0);
  endfunction

  function automatic bit eff(int c, int p);
    return bus_a.we[p] && live(c, wa(p));
  endfunction

  function automatic logic [WIDTH-1:0] exp_rdata(int c, int r);
    logic [WIDTH-1:0] v;
    if (!live(c, ra(r))) return '0;
    v = m_mem[c][ra(r)];
    if (c == 0) begin
      for (int p = 0; p < int'(NUM_WR); p++) if (eff(c, p) && wa(p) == ra(r)) v = wd(p);
    end
    return v;
  endfunction

  function automatic logic exp_rbusy(int c, int r);
    logic v;
    if (!live(c, ra(r))) return 1'b0;
    v = m_busy[c][ra(r)];
    if (c == 0) begin
      for (int p = 0; p < int'(NUM_WR); p++) if (eff(c, p) && wa(p) == ra(r)) v = 1'b0;
    end
    return v;
  endfunction

  function automatic logic [DEPTH-1:0] exp_busyvec(int c);
    logic [DEPTH-1:0] v;
    for (int a = 0; a < int'(DEPTH); a++) v[a] = m_busy[c][a];
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] got_rdata(int c, int r);
    return (c == 0) ? bus_a.rdata[r*WIDTH +: WIDTH] : bus_b.rdata[r*WIDTH +: WIDTH];
  endfunction

  function automatic logic got_rbusy(int c, int r);
    return (c == 0) ? bus_a.rbusy[r] : bus_b.rbusy[r];
  endfunction

  function automatic logic [DEPTH-1:0] got_busyvec(int c);
    return (c == 0) ? bus_a.busy_vec : bus_b.busy_vec;
  endfunction

  function automatic logic got_conf(int c);
    return (c == 0) ? bus_a.wr_conflict : bus_b.wr_conflict;
  endfunction

  task automatic model_tick();
    int hits [DEPTH];
    for (int c = 0; c < 2; c++) begin
      if (!reset_n) begin
        for (int a = 0; a < int'(DEPTH); a++) begin
          m_mem[c][a]  = '0;
          m_busy[c][a] = 1'b0;
        end
        m_conf[c] = 1'b0;
      end else begin
        for (int a = 0; a < int'(DEPTH); a++) hits[a] = 0;
        for (int p = 0; p < int'(NUM_WR); p++) begin
          if (eff(c, p)) begin
            hits[wa(p)]++;
            m_mem[c][wa(p)]  = wd(p);
            m_busy[c][wa(p)] = 1'b0;
          end
        end
        m_conf[c] = 1'b0;
        for (int a = 0; a < int'(DEPTH); a++) if (hits[a] >= 2) m_conf[c] = 1'b1;
        if (bus_a.busy_set && live(c, bus_a.busy_set_addr)) m_busy[c][bus_a.busy_set_addr] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle();
    bus_a.we            = '0;
    bus_a.waddr         = '0;
    bus_a.wdata         = '0;
    bus_a.raddr         = '0;
    bus_a.busy_set      = 1'b0;
    bus_a.busy_set_addr = '0;
  endtask

  task automatic set_wr(int p, logic [AW-1:0] a, logic [WIDTH-1:0] d);
    bus_a.we[p]                  = 1'b1;
    bus_a.waddr[p*AW +: AW]      = a;
    bus_a.wdata[p*WIDTH +: WIDTH] = d;
  endtask

  task automatic set_rd(int r, logic [AW-1:0] a);
    bus_a.raddr[r*AW +: AW] = a;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    set_wr(0, 5'd4, 32'h1234_5678);
    bus_a.busy_set      = 1'b1;
    bus_a.busy_set_addr = 5'd6;
    tick();
    tick();
    reset_n = 1'b1;
    idle();
    for (int a = 0; a < 32; a += int'(NUM_RD)) begin
      for (int r = 0; r < int'(NUM_RD); r++) set_rd(r, 5'(a + r));
      #1;
      for (int c = 0; c < 2; c++) begin
        for (int r = 0; r < int'(NUM_RD); r++) begin
          total++;
          if (got_rdata(c, r) !== '0 || got_rbusy(c, r) !== 1'b0) begin
            bad++;
            $display("FAIL reset_read c%0d addr%0d got=%h/%b want=0/0",
                     c, a + r, got_rdata(c, r), got_rbusy(c, r));
          end
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      total++;
      if (got_busyvec(c) !== '0 || got_conf(c) !== 1'b0) begin
        bad++;
        $display("FAIL reset_state c%0d busy_vec=%h conflict=%b want 0/0",
                 c, got_busyvec(c), got_conf(c));
      end
    end
  endtask

  task automatic test_zero_reg();
    idle();
    set_wr(0, 5'd0, 32'hDEAD_BEEF);
    #1;
    total++;
    if (got_rdata(0, 0) !== 32'h0 || got_rdata(1, 0) !== 32'h0) begin
      bad++;
      $display("FAIL x0_same_cycle got a=%h b=%h want 0/0", got_rdata(0, 0), got_rdata(1, 0));
    end
    tick();
    idle();
    #1;
    total++;
    if (got_rdata(0, 0) !== 32'h0 || got_rdata(1, 0) !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL x0_after got a=%h b=%h want 0/deadbeef", got_rdata(0, 0), got_rdata(1, 0));
    end
  endtask

  task automatic test_conflict();
    idle();
    set_wr(0, 5'd5, 32'h11);
    set_wr(1, 5'd5, 32'h22);
    tick();
    idle();
    set_rd(0, 5'd5);
    #1;
    for (int c = 0; c < 2; c++) begin
      total++;
      if (got_rdata(c, 0) !== 32'h22 || got_conf(c) !== 1'b1) begin
        bad++;
        $display("FAIL conflict_pair c%0d got=%h/%b want 22/1", c, got_rdata(c, 0), got_conf(c));
      end
    end
    tick();
    for (int c = 0; c < 2; c++) begin
      total++;
      if (got_conf(c) !== 1'b0) begin
        bad++;
        $display("FAIL conflict_pulse c%0d got=%b want 0", c, got_conf(c));
      end
    end
    set_wr(0, 5'd9, 32'h31);
    set_wr(1, 5'd9, 32'h32);
    set_wr(2, 5'd9, 32'h33);
    tick();
    idle();
    set_rd(1, 5'd9);
    #1;
    for (int c = 0; c < 2; c++) begin
      total++;
      if (got_rdata(c, 1) !== 32'h33 || got_conf(c) !== 1'b1) begin
        bad++;
        $display("FAIL conflict_three c%0d got=%h/%b want 33/1", c, got_rdata(c, 1), got_conf(c));
      end
    end
    // Two writes to x0: ineffective in the integer config, a real conflict in the FP one.
    set_wr(0, 5'd0, 32'h1);
    set_wr(1, 5'd0, 32'h2);
    set_wr(2, 5'd30, 32'h3);
    tick();
    idle();
    total++;
    if (got_conf(0) !== 1'b0 || got_conf(1) !== 1'b1) begin
      bad++;
      $display("FAIL conflict_x0 got a=%b b=%b want 0/1", got_conf(0), got_conf(1));
    end
    set_wr(0, 5'd30, 32'h4);
    set_wr(1, 5'd30, 32'h5);
    tick();
    idle();
    for (int c = 0; c < 2; c++) begin
      total++;
      if (got_conf(c) !== 1'b0) begin
        bad++;
        $display("FAIL conflict_invalid c%0d got=%b want 0", c, got_conf(c));
      end
    end
  endtask

  task automatic test_bypass();
    idle();
    set_wr(2, 5'd7, 32'h1234);
    tick();
    idle();
    set_rd(0, 5'd7);
    set_wr(1, 5'd7, 32'hA5A5);
    #1;
    total++;
    if (got_rdata(0, 0) !== 32'hA5A5 || got_rdata(1, 0) !== 32'h1234) begin
      bad++;
      $display("FAIL bypass_same got a=%h b=%h want a5a5/1234", got_rdata(0, 0), got_rdata(1, 0));
    end
    tick();
    idle();
    set_rd(0, 5'd7);
    #1;
    for (int c = 0; c < 2; c++) begin
      total++;
      if (got_rdata(c, 0) !== 32'hA5A5) begin
        bad++;
        $display("FAIL bypass_next c%0d got=%h want a5a5", c, got_rdata(c, 0));
      end
    end
  endtask

  task automatic test_busy();
    idle();
    bus_a.busy_set      = 1'b1;
    bus_a.busy_set_addr = 5'd3;
    tick();
    idle();
    tick();
    tick();
    set_rd(0, 5'd3);
    #1;
    for (int c = 0; c < 2; c++) begin
      total++;
      if (got_rbusy(c, 0) !== 1'b1 || got_busyvec(c) !== 24'h8) begin
        bad++;
        $display("FAIL busy_set c%0d got=%b/%h want 1/000008", c, got_rbusy(c, 0), got_busyvec(c));
      end
    end
    set_wr(0, 5'd3, 32'h77);
    bus_a.busy_set      = 1'b1;
    bus_a.busy_set_addr = 5'd3;
    #1;
    total++;
    if (got_rbusy(0, 0) !== 1'b0 || got_rbusy(1, 0) !== 1'b1) begin
      bad++;
      $display("FAIL busy_fwd got a=%b b=%b want 0/1", got_rbusy(0, 0), got_rbusy(1, 0));
    end
    tick();
    idle();
    for (int c = 0; c < 2; c++) begin
      total++;
      if (got_busyvec(c) !== 24'h8) begin
        bad++;
        $display("FAIL busy_set_wins c%0d got=%h want 000008", c, got_busyvec(c));
      end
    end
    set_wr(1, 5'd3, 32'h78);
    bus_a.busy_set      = 1'b1;
    bus_a.busy_set_addr = 5'd0;
    tick();
    idle();
    bus_a.busy_set      = 1'b1;
    bus_a.busy_set_addr = 5'd30;
    set_rd(2, 5'd0);
    #1;
    total++;
    if (got_busyvec(0) !== 24'h0 || got_busyvec(1) !== 24'h1 || got_rbusy(1, 2) !== 1'b1) begin
      bad++;
      $display("FAIL busy_clear_x0 got a=%h b=%h rb=%b want 000000/000001/1",
               got_busyvec(0), got_busyvec(1), got_rbusy(1, 2));
    end
    tick();
    idle();
    set_wr(0, 5'd0, 32'h0);
    tick();
    idle();
    for (int c = 0; c < 2; c++) begin
      total++;
      if (got_busyvec(c) !== exp_busyvec(c)) begin
        bad++;
        $display("FAIL busy_invalid c%0d got=%h want=%h", c, got_busyvec(c), exp_busyvec(c));
      end
    end
  endtask

  task automatic test_reset_mid();
    idle();
    for (int i = 1; i <= 4; i++) begin
      set_wr(0, 5'(i), 32'(100 + i));
      tick();
    end
    idle();
    reset_n = 1'b0;
    set_wr(0, 5'd2, 32'hFFFF);
    bus_a.busy_set      = 1'b1;
    bus_a.busy_set_addr = 5'd4;
    tick();
    reset_n = 1'b1;
    idle();
    for (int base = 1; base <= 4; base += int'(NUM_RD)) begin
      for (int r = 0; r < int'(NUM_RD); r++) set_rd(r, 5'(base + r));
      #1;
      for (int c = 0; c < 2; c++) begin
        for (int r = 0; r < int'(NUM_RD); r++) begin
          total++;
          if (got_rdata(c, r) !== '0) begin
            bad++;
            $display("FAIL reset_mid c%0d x%0d got=%h want 0", c, base + r, got_rdata(c, r));
          end
        end
        total++;
        if (got_busyvec(c) !== '0) begin
          bad++;
          $display("FAIL reset_mid_busy c%0d got=%h want 0", c, got_busyvec(c));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      idle();
      reset_n = ($urandom_range(0, 59) != 0);
      for (int p = 0; p < int'(NUM_WR); p++) begin
        if ($urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 1) == 1) set_wr(p, 5'($urandom_range(0, 3)), $urandom);
          else set_wr(p, 5'($urandom_range(0, 31)), $urandom);
        end
      end
      for (int r = 0; r < int'(NUM_RD); r++) begin
        set_rd(r, ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31)));
      end
      bus_a.busy_set      = ($urandom_range(0, 2) != 0);
      bus_a.busy_set_addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3))
                                                        : 5'($urandom_range(0, 31));
      #1;
      for (int c = 0; c < 2; c++) begin
        for (int r = 0; r < int'(NUM_RD); r++) begin
          total++;
          if (got_rdata(c, r) !== exp_rdata(c, r)) begin
            bad++;
            $display("FAIL rand_rdata cyc%0d c%0d r%0d got=%h want=%h",
                     cyc, c, r, got_rdata(c, r), exp_rdata(c, r));
          end
          total++;
          if (got_rbusy(c, r) !== exp_rbusy(c, r)) begin
            bad++;
            $display("FAIL rand_rbusy cyc%0d c%0d r%0d got=%b want=%b",
                     cyc, c, r, got_rbusy(c, r), exp_rbusy(c, r));
          end
        end
      end
      tick();
      for (int c = 0; c < 2; c++) begin
        total++;
        if (got_busyvec(c) !== exp_busyvec(c) || got_conf(c) !== m_conf[c]) begin
          bad++;
          $display("FAIL rand_state cyc%0d c%0d got=%h/%b want=%h/%b",
                   cyc, c, got_busyvec(c), got_conf(c), exp_busyvec(c), m_conf[c]);
        end
      end
    end
    reset_n = 1'b1;
    idle();
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    tick();
    test_reset();
    test_zero_reg();
    test_conflict();
    test_bypass();
    test_busy();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
